score_keeper: RTL and testbench

- Downstream consumer of the game controller's ball position and countdown outputs.
- Detects goals when the ball enters either goal mouth, maintains saturating per-team scores, and holds a freeze window after each goal.
- Declares game over when the countdown reaches zero.
- Outputs feed the display/renderer stage.

---
 rtl/quidditch_pkg.sv | 36 +++
 rtl/goal_zone_detect.sv | 53 +++++
 rtl/score_keeper.sv | 163 ++++++++++++++++
 tb/tb_score_keeper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/quidditch_pkg.sv
// ============================================================================
//  Module   : quidditch_pkg
//  Purpose  : Shared types, widths and team encoding for the score keeper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package quidditch_pkg;

    // Game phases seen by the score keeper
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        HOLD  = 2'd1,
        REARM = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int SCORE_W = 7;
    localparam int POS_W   = 19;
    // Zone comparisons carry one extra bit so x + radius cannot wrap
    localparam int CMP_W   = POS_W + 1;

    localparam logic TEAM1 = 1'b0;
    localparam logic TEAM2 = 1'b1;

    // Increment a score, pinning it at the saturation value
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] max_value
    );
        return (value >= max_value) ? max_value : value + SCORE_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/goal_zone_detect.sv
// ============================================================================
//  Module   : goal_zone_detect
//  Purpose  : Combinational test of whether the ball edge touches one goal
//             line while its centre lies inside the goal-mouth window.
//             SIDE = 0 : left goal  (x <= GOAL_X + BALL_RADIUS)
//             SIDE = 1 : right goal (x + BALL_RADIUS >= GOAL_X)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module goal_zone_detect
    import quidditch_pkg::*;
#(
    parameter int GOAL_X          = 10,
    parameter bit SIDE            = 1'b0,
    parameter int SCREEN_CENTER_Y = 240,
    parameter int GOAL_RADIUS     = 40,
    parameter int BALL_RADIUS     = 8
) (
    input  logic [POS_W-1:0] ball_x,
    input  logic [POS_W-1:0] ball_y,
    output logic             hit
);

    localparam logic [CMP_W-1:0] Y_LO = CMP_W'(SCREEN_CENTER_Y - GOAL_RADIUS);
    localparam logic [CMP_W-1:0] Y_HI = CMP_W'(SCREEN_CENTER_Y + GOAL_RADIUS);

    logic [CMP_W-1:0] x_ext;
    logic [CMP_W-1:0] y_ext;
    logic             in_window;
    logic             edge_touch;

    assign x_ext     = {1'b0, ball_x};
    assign y_ext     = {1'b0, ball_y};
    assign in_window = (y_ext >= Y_LO) && (y_ext <= Y_HI);

    // Edge test differs per side; x is never subtracted so it cannot underflow
    generate
        if (SIDE == 1'b0) begin : g_left
            localparam logic [CMP_W-1:0] X_LIM = CMP_W'(GOAL_X + BALL_RADIUS);
            assign edge_touch = (x_ext <= X_LIM);
        end else begin : g_right
            localparam logic [CMP_W-1:0] X_LINE = CMP_W'(GOAL_X);
            localparam logic [CMP_W-1:0] RADIUS = CMP_W'(BALL_RADIUS);
            assign edge_touch = ((x_ext + RADIUS) >= X_LINE);
        end
    endgenerate

    assign hit = edge_touch && in_window;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Goal detection, saturating per-team scores, post-goal freeze
//             window and sticky game-over flag for the display stage.
//  Option   : SCORE_KEEPER_GOLDEN_GOAL_EN - a tied score when the clock runs
//             out keeps play going until the next counted goal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper
    import quidditch_pkg::*;
#(
    parameter int SCREEN_CENTER_Y = 240,
    parameter int GOAL_RADIUS     = 40,
    parameter int BALL_RADIUS     = 8,
    parameter int LEFT_GOAL_X     = 10,
    parameter int RIGHT_GOAL_X    = 630,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int SCORE_MAX       = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [POS_W-1:0]   ball_hor_position,
    input  logic [POS_W-1:0]   ball_ver_position,
    input  logic [7:0]         time_left,
    output logic [SCORE_W-1:0] team1_score,
    output logic [SCORE_W-1:0] team2_score,
    output logic               goal_pulse,
    output logic               goal_team,
    output logic               freeze,
    output logic               game_over
);

    localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

    state_t              state_q,      state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [SCORE_W-1:0]  team1_q,      team1_d;
    logic [SCORE_W-1:0]  team2_q,      team2_d;
    logic                goal_pulse_q, goal_pulse_d;
    logic                goal_team_q,  goal_team_d;

    logic left_hit;
    logic right_hit;
    logic end_game;

    goal_zone_detect #(
        .GOAL_X          (LEFT_GOAL_X),
        .SIDE            (1'b0),
        .SCREEN_CENTER_Y (SCREEN_CENTER_Y),
        .GOAL_RADIUS     (GOAL_RADIUS),
        .BALL_RADIUS     (BALL_RADIUS)
    ) u_left_zone (
        .ball_x (ball_hor_position),
        .ball_y (ball_ver_position),
        .hit    (left_hit)
    );

    goal_zone_detect #(
        .GOAL_X          (RIGHT_GOAL_X),
        .SIDE            (1'b1),
        .SCREEN_CENTER_Y (SCREEN_CENTER_Y),
        .GOAL_RADIUS     (GOAL_RADIUS),
        .BALL_RADIUS     (BALL_RADIUS)
    ) u_right_zone (
        .ball_x (ball_hor_position),
        .ball_y (ball_ver_position),
        .hit    (right_hit)
    );

`ifdef SCORE_KEEPER_GOLDEN_GOAL_EN
    // A tie at zero keeps the game alive; the next goal breaks the tie
    assign end_game = (time_left == 8'd0) && (team1_q != team2_q);
`else
    assign end_game = (time_left == 8'd0);
`endif

    // Next-state, score update and goal strobe; time-out outranks any goal
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        team1_d      = team1_q;
        team2_d      = team2_q;
        goal_team_d  = goal_team_q;
        goal_pulse_d = 1'b0;

        case (state_q)
            PLAY: begin
                if (end_game) begin
                    state_d = OVER;
                end else if (left_hit) begin
                    // Left wins if both zones ever fire together
                    team2_d      = sat_inc(team2_q, SCORE_CAP);
                    goal_team_d  = TEAM2;
                    goal_pulse_d = 1'b1;
                    hold_cnt_d   = '0;
                    state_d      = HOLD;
                end else if (right_hit) begin
                    team1_d      = sat_inc(team1_q, SCORE_CAP);
                    goal_team_d  = TEAM1;
                    goal_pulse_d = 1'b1;
                    hold_cnt_d   = '0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (end_game) begin
                    state_d = OVER;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = REARM;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            REARM: begin
                // Wait for the ball to leave both mouths so one goal counts once
                if (end_game) begin
                    state_d = OVER;
                end else if (!left_hit && !right_hit) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // State, counter and score registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLAY;
            hold_cnt_q   <= '0;
            team1_q      <= '0;
            team2_q      <= '0;
            goal_pulse_q <= 1'b0;
            goal_team_q  <= TEAM1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            team1_q      <= team1_d;
            team2_q      <= team2_d;
            goal_pulse_q <= goal_pulse_d;
            goal_team_q  <= goal_team_d;
        end
    end

    assign team1_score = team1_q;
    assign team2_score = team2_q;
    assign goal_pulse  = goal_pulse_q;
    assign goal_team   = goal_team_q;
    assign freeze      = (state_q == HOLD);
    assign game_over   = (state_q == OVER);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Self-checking bench for score_keeper against a behavioural
//             model of the game rules. Honours SCORE_KEEPER_GOLDEN_GOAL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;
    import quidditch_pkg::*;

    localparam int HOLD = 20;
`ifdef SCORE_KEEPER_GOLDEN_GOAL_EN
    localparam bit GOLDEN = 1'b1;
`else
    localparam bit GOLDEN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [POS_W-1:0]   bx;
    logic [POS_W-1:0]   by;
    logic [7:0]         tl;
    logic [SCORE_W-1:0] team1_score;
    logic [SCORE_W-1:0] team2_score;
    logic               goal_pulse;
    logic               goal_team;
    logic               freeze;
    logic               game_over;

    int total  = 0;
    int passed = 0;

    // Reference model of the game rules
    int m_s1, m_s2, m_team, m_pulse, m_over, m_freeze_left, m_wait_clear;

    score_keeper #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ball_hor_position (bx),
        .ball_ver_position (by),
        .time_left         (tl),
        .team1_score       (team1_score),
        .team2_score       (team2_score),
        .goal_pulse        (goal_pulse),
        .goal_team         (goal_team),
        .freeze            (freeze),
        .game_over         (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_team = 0; m_pulse = 0;
        m_over = 0; m_freeze_left = 0; m_wait_clear = 0;
    endtask

    // One clock edge of the game as described by the rules
    task automatic model_edge(input int x, input int y, input int t);
        bit win, lhit, rhit, stop;
        win  = (y >= 200) && (y <= 280);
        lhit = win && (x <= 18);
        rhit = win && (x + 8 >= 630);
        stop = (t == 0) && !(GOLDEN && (m_s1 == m_s2));
        m_pulse = 0;
        if (m_over != 0) begin
            // game finished; nothing moves
        end else if (m_freeze_left > 0) begin
            if (stop) begin
                m_over = 1; m_freeze_left = 0;
            end else begin
                m_freeze_left--;
                if (m_freeze_left == 0) m_wait_clear = 1;
            end
        end else if (m_wait_clear != 0) begin
            if (stop) m_over = 1;
            else if (!lhit && !rhit) m_wait_clear = 0;
        end else begin
            if (stop) m_over = 1;
            else if (lhit) begin
                m_s2 = (m_s2 >= 99) ? 99 : m_s2 + 1;
                m_team = 1; m_pulse = 1; m_freeze_left = HOLD;
            end else if (rhit) begin
                m_s1 = (m_s1 >= 99) ? 99 : m_s1 + 1;
                m_team = 0; m_pulse = 1; m_freeze_left = HOLD;
            end
        end
    endtask

    task automatic check_all();
        chk("team1_score", 32'(team1_score), 32'(m_s1));
        chk("team2_score", 32'(team2_score), 32'(m_s2));
        chk("goal_pulse",  32'(goal_pulse),  32'(m_pulse));
        chk("goal_team",   32'(goal_team),   32'(m_team));
        chk("freeze",      32'(freeze),      32'((m_over == 0) && (m_freeze_left > 0)));
        chk("game_over",   32'(game_over),   32'(m_over));
    endtask

    task automatic step(input int x, input int y, input int t);
        @(negedge clk);
        bx = POS_W'(x); by = POS_W'(y); tl = 8'(t);
        @(posedge clk);
        model_edge(x, y, t);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input int t);
        for (int i = 0; i < n; i++) step(320, 240, t);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        bx = 19'd320; by = 19'd240; tl = 8'd180;
        model_reset();
        do_reset();

        // Quiet play in midfield
        idle(100, 180);

        // Left goal, then ball parked in the mouth blocks a second goal
        step(15, 240, 180);
        for (int i = 0; i < HOLD + 5; i++) step(15, 240, 180);
        step(18, 240, 180);
        step(19, 240, 180);
        idle(3, 180);

        // Right goal, out-of-window miss, inclusive window edge
        step(625, 200, 180);
        idle(HOLD + 2, 180);
        step(625, 150, 180);
        step(625, 150, 180);
        step(622, 280, 180);
        idle(HOLD + 2, 180);

        // Randomised play around both mouths and window edges
        for (int i = 0; i < 400; i++) begin
            int x, y;
            case ($urandom_range(0, 7))
                0: x = 18;
                1: x = 19;
                2: x = 0;
                3: x = 621;
                4: x = 622;
                5: x = 700;
                default: x = int'($urandom_range(0, 700));
            endcase
            case ($urandom_range(0, 5))
                0: y = 199;
                1: y = 200;
                2: y = 280;
                3: y = 281;
                default: y = int'($urandom_range(150, 330));
            endcase
            step(x, y, 180);
        end
        idle(HOLD + 2, 180);

        // Drive team 1 into saturation; pulses continue at the cap
        for (int i = 0; i < 102; i++) begin
            step(630, 240, 180);
            idle(HOLD + 2, 180);
        end

        // Reset while frozen after a goal
        step(5, 240, 180);
        idle(5, 180);
        do_reset();
        idle(2, 180);

        // Time-out beats a simultaneous goal; later goals ignored
        step(630, 240, 180);
        idle(HOLD + 2, 180);
        step(5, 240, 0);
        step(5, 240, 180);
        step(630, 240, 180);
        idle(3, 180);

`ifdef SCORE_KEEPER_GOLDEN_GOAL_EN
        // Tied 2/2 at zero: play continues until the next goal
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(5, 240, 180);
            idle(HOLD + 2, 180);
            step(630, 240, 180);
            idle(HOLD + 2, 180);
        end
        idle(5, 0);
        step(5, 240, 0);
        step(320, 240, 0);
        idle(3, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
